mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Memory-stage controller between the EX/MEM latch and the MEM/WB latch. It issues load/store requests to a variable-latency data memory and holds the pipeline with `dataMem_stall` until the memory completes. It marks the completion cycle with `done_mem` and presents the load result on `read_data_m`. It also detects misaligned accesses and memory timeouts, and converts either one into a halt.

## Interface
Parameters:
- `TIMEOUT`, default 31: maximum number of BUSY cycles before a timeout error; legal range 1..255.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `MemRead_m` in 1: the MEM-stage instruction is a load.
- `MemWrite_m` in 1: the MEM-stage instruction is a store. Never asserted together with `MemRead_m`.
- `exec_out_m` in 16: byte address of the access.
- `write_data_m` in 16: store data.
- `halt_m` in 1: the MEM-stage instruction is HALT.
- `mem_rd` out 1: read request strobe to data memory.
- `mem_wr` out 1: write request strobe to data memory.
- `mem_addr` out 16: request address (= `exec_out_m`).
- `mem_wdata` out 16: request write data (= `write_data_m`).
- `mem_rdata` in 16: memory read data, valid only when `mem_done`=1.
- `mem_done` in 1: memory completion pulse.
- `read_data_m` out 16: load result toward the MEM/WB latch.
- `dataMem_stall` out 1: freeze upstream stages and hold the MEM/WB latch.
- `done_mem` out 1: access completes this cycle.
- `err_m` out 1: sticky error flag (misalign or timeout).
- `halt_out` out 1: halt request toward the MEM/WB latch.
- `stall_cnt` out 16: saturating count of cycles with `dataMem_stall`=1.

## Operation
- Access valid: `acc = (MemRead_m | MemWrite_m)`, qualified by state IDLE.
- Misaligned: `acc & exec_out_m[0]`.
- States: IDLE, BUSY, HALTED.
- **IDLE, no access:** no request. If `halt_m`=1, go to HALTED.
- **IDLE, aligned access:** pulse `mem_rd` or `mem_wr` for exactly this cycle.
  - `mem_done`=1 in the same cycle (hit): `done_mem`=1, `dataMem_stall`=0, stay in IDLE.
  - Otherwise: `dataMem_stall`=1, go to BUSY, load `to_cnt`=0.
- **IDLE, misaligned access:** no request is issued. `err_m` sets and `halt_out`=1 this cycle; go to HALTED.
- **BUSY:** `mem_rd` and `mem_wr` stay 0. `dataMem_stall`=1 while `mem_done`=0, and `to_cnt` increments each cycle.
  - On `mem_done`=1: `dataMem_stall`=0, `done_mem`=1, return to IDLE. For a load, `mem_rdata` is captured into `rdata_q`.
  - If `to_cnt`==`TIMEOUT` with `mem_done`=0: set `err_m`, `dataMem_stall`=0, `halt_out`=1, go to HALTED.
- **HALTED:**
  - No further requests; `mem_done` is ignored.
  - `halt_out`=1 and `dataMem_stall`=0 continuously.
  - Left only by reset.
- `read_data_m = mem_done ? mem_rdata : rdata_q`. The combinational path makes data available in the completion cycle.
- `halt_out` in IDLE equals `halt_m`.
- `mem_done` arriving in IDLE without a request in the same cycle is ignored; `rdata_q` is unchanged.
- `stall_cnt` increments every cycle `dataMem_stall`=1 and saturates at 16'hFFFF.
- The opcode is latched on entry to BUSY (`is_load_q`). Input changes while in BUSY have no effect.

## Timing
- Reset (`rst`=0, asynchronous), all outputs and state forced immediately:
  - state = IDLE; `rdata_q`, `to_cnt`, `stall_cnt`, `err_m` = 0.
  - `mem_rd`, `mem_wr`, `dataMem_stall`, `done_mem`, `halt_out` = 0.
  - `read_data_m` = 0 unless `mem_done`=1.
- Reset deassertion takes effect at the next rising edge.
- Hit: zero stall cycles; `done_mem` is high in the issue cycle.
- Miss with `mem_done` N cycles after issue: `dataMem_stall`=1 for N cycles (issue cycle through N-1). `done_mem`=1 in cycle N.
- Requests are single-cycle pulses. A new request can issue in the cycle after completion.
- `mem_done` and timeout in the same cycle: `mem_done` wins; normal completion, no error.
- Reset during BUSY: the outstanding request is abandoned; a late `mem_done` after reset is ignored in IDLE.
- `err_m` stays set until reset.

## Test plan
- Load hit: `MemRead_m`=1, `exec_out_m`=16'h0010, `mem_done`=1 with `mem_rdata`=16'hBEEF in the same cycle -> `mem_rd` pulses 1 cycle, `done_mem`=1, `dataMem_stall`=0, `read_data_m`=16'hBEEF; next cycle `read_data_m` still 16'hBEEF.
- Store miss: `MemWrite_m`=1, addr 16'h0040, wdata 16'h1234, `mem_done` 3 cycles later -> `mem_wr` high 1 cycle, `dataMem_stall`=1 for 3 cycles, `done_mem`=1 on cycle 3, `stall_cnt`=3.
- Misalign: `MemRead_m`=1, addr 16'h0013 -> no `mem_rd`, `err_m`=1, `halt_out`=1; later loads issue nothing.
- Timeout: `TIMEOUT`=4, load with no `mem_done` -> stall for 5 cycles, then `err_m`=1, `halt_out`=1, `dataMem_stall`=0; a late `mem_done` leaves `rdata_q` unchanged.
- Halt: `halt_m`=1 with no access -> `halt_out`=1 that cycle and every following cycle; a subsequent `MemWrite_m` produces no `mem_wr`.
- Reset mid-miss: `rst`=0 during BUSY -> `dataMem_stall`, `stall_cnt`, `err_m` = 0 immediately; a stray `mem_done` afterwards gives `done_mem`=0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues single-cycle load/store strobes to a variable-latency
// data memory, stalls the pipeline until completion, and halts on misalignment or timeout.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_m,
  input  logic        MemWrite_m,
  input  logic [15:0] exec_out_m,
  input  logic [15:0] write_data_m,
  input  logic        halt_m,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic [15:0] read_data_m,
  output logic        dataMem_stall,
  output logic        done_mem,
  output logic        err_m,
  output logic        halt_out,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HALTED
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        is_load_q, is_load_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] stall_cnt_q;

  logic        acc, misalign;
  logic        rd_i, wr_i, stall_i, done_i, halt_i;

  assign acc      = (MemRead_m | MemWrite_m) & (state_q == IDLE);
  assign misalign = acc & exec_out_m[0];

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    is_load_d = is_load_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    rd_i      = 1'b0;
    wr_i      = 1'b0;
    stall_i   = 1'b0;
    done_i    = 1'b0;
    halt_i    = 1'b0;
    case (state_q)
      IDLE: begin
        if (misalign) begin
          halt_i  = 1'b1;
          err_d   = 1'b1;
          state_d = HALTED;
        end else if (acc) begin
          rd_i = MemRead_m;
          wr_i = MemWrite_m;
          if (mem_done) begin
            done_i = 1'b1;
            if (MemRead_m) rdata_d = mem_rdata;
          end else begin
            stall_i   = 1'b1;
            state_d   = BUSY;
            to_cnt_d  = '0;
            is_load_d = MemRead_m;
          end
        end else begin
          halt_i = halt_m;
          if (halt_m) state_d = HALTED;
        end
      end
      BUSY: begin
        // completion takes priority over a timeout landing in the same cycle
        if (mem_done) begin
          done_i  = 1'b1;
          state_d = IDLE;
          if (is_load_q) rdata_d = mem_rdata;
        end else if (to_cnt_q == TO_LIM) begin
          err_d   = 1'b1;
          halt_i  = 1'b1;
          state_d = HALTED;
        end else begin
          stall_i  = 1'b1;
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      HALTED: halt_i = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      is_load_q   <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      is_load_q <= is_load_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      if (stall_i && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // Control outputs are forced low for as long as reset is held, not just after an edge.
  assign mem_rd        = rst & rd_i;
  assign mem_wr        = rst & wr_i;
  assign dataMem_stall = rst & stall_i;
  assign done_mem      = rst & done_i;
  assign halt_out      = rst & halt_i;

  assign mem_addr    = exec_out_m;
  assign mem_wdata   = write_data_m;
  assign read_data_m = mem_done ? mem_rdata : rdata_q;
  assign err_m       = err_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
